// File: rtl/lin_tx_frame_feeder.sv
// rtl/lin_tx_frame_feeder.sv - 16x32 TX memory feeding LIN frames (data + checksum) to a byte serializer.
// Optional macro LIN_ENHANCED_CKSUM_EN adds pid_i and seeds the checksum with it (LIN 2.x enhanced).
module lin_tx_frame_feeder #(
  parameter int data_width     = 32,
  parameter int mem_addr_width = 4
) (
  input  logic                      pclk,
  input  logic                      preset_i,
  input  logic                      tx_mem_we,
  input  logic [mem_addr_width-1:0] tx_addr,
  input  logic [data_width-1:0]     tx_mem_data,
  input  logic                      start_i,
  input  logic [2:0]                slot_i,
  input  logic [3:0]                dlc_i,
`ifdef LIN_ENHANCED_CKSUM_EN
  input  logic [7:0]                pid_i,
`endif
  output logic [7:0]                byte_o,
  output logic                      byte_valid_o,
  input  logic                      byte_ready_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [7:0]                cksum_o
);

  localparam int depth = 1 << mem_addr_width;

  typedef enum logic [1:0] {IDLE, LOAD, SEND_DATA, SEND_CKSUM} state_t;

  state_t                  state_q, state_d;
  logic [data_width-1:0]   mem_q [depth];
  logic [data_width-1:0]   mem_d [depth];
  logic [2:0]              slot_q, slot_d;
  logic [3:0]              dlc_q, dlc_d;
  logic [2*data_width-1:0] shadow_q, shadow_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [7:0]              sum_q, sum_d;
  logic [7:0]              cksum_q, cksum_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic [mem_addr_width-1:0] addr0, addr1;
  logic [7:0]                cur_byte;
  logic [8:0]                sum_add;
  logic [7:0]                sum_wrap;
  logic [7:0]                sum_init;
  logic                      last_byte;

`ifdef LIN_ENHANCED_CKSUM_EN
  assign sum_init = pid_i;
`else
  assign sum_init = 8'h00;
`endif

  assign addr0     = mem_addr_width'({slot_q, 1'b0});
  assign addr1     = mem_addr_width'({slot_q, 1'b1});
  assign cur_byte  = shadow_q[{cnt_q, 3'b000} +: 8];
  // LIN checksum: 8-bit add with the carry folded back in
  assign sum_add   = {1'b0, sum_q} + {1'b0, cur_byte};
  assign sum_wrap  = sum_add[7:0] + {7'b0, sum_add[8]};
  assign last_byte = (cnt_q == 3'(dlc_q - 4'd1));

  always_comb begin
    state_d      = state_q;
    mem_d        = mem_q;
    slot_d       = slot_q;
    dlc_d        = dlc_q;
    shadow_d     = shadow_q;
    cnt_d        = cnt_q;
    sum_d        = sum_q;
    cksum_d      = cksum_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    byte_o       = 8'h00;
    byte_valid_o = 1'b0;

    if (tx_mem_we) mem_d[tx_addr] = tx_mem_data;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (dlc_i != 4'd0 && dlc_i <= 4'd8) begin
            slot_d  = slot_i;
            dlc_d   = dlc_i;
            sum_d   = sum_init;
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        // Snapshot uses the pre-write array, so a same-cycle write is not seen
        shadow_d = {mem_q[addr1], mem_q[addr0]};
        cnt_d    = 3'd0;
        state_d  = SEND_DATA;
      end
      SEND_DATA: begin
        byte_valid_o = 1'b1;
        byte_o       = cur_byte;
        if (byte_ready_i) begin
          sum_d = sum_wrap;
          cnt_d = cnt_q + 3'd1;
          if (last_byte) state_d = SEND_CKSUM;
        end
      end
      SEND_CKSUM: begin
        byte_valid_o = 1'b1;
        byte_o       = ~sum_q;
        if (byte_ready_i) begin
          cksum_d = ~sum_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_i) begin
    if (!preset_i) begin
      state_q  <= IDLE;
      mem_q    <= '{default: '0};
      slot_q   <= '0;
      dlc_q    <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cksum_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      slot_q   <= slot_d;
      dlc_q    <= dlc_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cksum_q  <= cksum_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign cksum_o = cksum_q;

endmodule

// File: tb/tb_lin_tx_frame_feeder.sv
// tb/tb_lin_tx_frame_feeder.sv - scoreboard bench for lin_tx_frame_feeder with directed frames.
module tb_lin_tx_frame_feeder;

  logic        pclk = 1'b0;
  logic        preset_i = 1'b0;
  logic        tx_mem_we = 1'b0;
  logic [3:0]  tx_addr = '0;
  logic [31:0] tx_mem_data = '0;
  logic        start_i = 1'b0;
  logic [2:0]  slot_i = '0;
  logic [3:0]  dlc_i = '0;
  logic [7:0]  pid_i = '0;
  logic [7:0]  byte_o;
  logic        byte_valid_o;
  logic        byte_ready_i = 1'b1;
  logic        busy_o, done_o, err_o;
  logic [7:0]  cksum_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

`ifdef LIN_ENHANCED_CKSUM_EN
  localparam logic [7:0] CK_BASIC = 8'hE6;
`else
  localparam logic [7:0] CK_BASIC = 8'h31;
`endif

  lin_tx_frame_feeder dut (
    .pclk         (pclk),
    .preset_i     (preset_i),
    .tx_mem_we    (tx_mem_we),
    .tx_addr      (tx_addr),
    .tx_mem_data  (tx_mem_data),
    .start_i      (start_i),
    .slot_i       (slot_i),
    .dlc_i        (dlc_i),
`ifdef LIN_ENHANCED_CKSUM_EN
    .pid_i        (pid_i),
`endif
    .byte_o       (byte_o),
    .byte_valid_o (byte_valid_o),
    .byte_ready_i (byte_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .cksum_o      (cksum_o)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted byte is matched against the scoreboard queue
  always @(negedge pclk) begin
    if (preset_i && byte_valid_o && byte_ready_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_byte: got %h, expected none", byte_o);
      end else begin
        check("stream_byte", {24'h0, byte_o}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    tx_mem_we = 1'b1; tx_addr = a; tx_mem_data = d;
    tick();
    tx_mem_we = 1'b0;
  endtask

  task automatic start(input logic [2:0] s, input logic [3:0] d, input logic [7:0] p);
    start_i = 1'b1; slot_i = s; dlc_i = d; pid_i = p;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done_o && cycles < 200) begin
      tick();
      cycles++;
    end
    if (!done_o) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int cyc;
    // Reset state
    tick(); tick();
    check("rst_valid", {31'b0, byte_valid_o}, 32'd0);
    check("rst_byte", {24'b0, byte_o}, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_done", {31'b0, done_o}, 32'd0);
    check("rst_err", {31'b0, err_o}, 32'd0);
    check("rst_cksum", {24'b0, cksum_o}, 32'd0);
    preset_i = 1'b1;
    tick();

    // Basic frame, latency and minimum length
    wr(4'd0, 32'h00E59355);
    exp_q.push_back(8'h55); exp_q.push_back(8'h93); exp_q.push_back(8'hE5); exp_q.push_back(CK_BASIC);
    start(3'd0, 4'd3, 8'h4A);
    check("load_valid", {31'b0, byte_valid_o}, 32'd0);
    check("load_busy", {31'b0, busy_o}, 32'd1);
    tick();
    check("first_valid", {31'b0, byte_valid_o}, 32'd1);
    wait_done(cyc);
    check("frame_len", cyc, 32'd4);
    check("basic_cksum", {24'b0, cksum_o}, {24'b0, CK_BASIC});
    check("done_busy", {31'b0, busy_o}, 32'd0);
    tick();
    check("done_pulse", {31'b0, done_o}, 32'd0);

    // Full-length frame with carry wrap
    wr(4'd14, 32'hFFFFFFFF);
    wr(4'd15, 32'hFFFFFFFF);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    start(3'd7, 4'd8, 8'h00);
    wait_done(cyc);
    check("wrap_cksum", {24'b0, cksum_o}, 32'h00);

    // Backpressure at byte 1
    exp_q.push_back(8'h55); exp_q.push_back(8'h93); exp_q.push_back(8'hE5); exp_q.push_back(CK_BASIC);
    start(3'd0, 4'd3, 8'h4A);
    tick(); tick();
    byte_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_byte", {24'b0, byte_o}, 32'h93);
      check("bp_valid", {31'b0, byte_valid_o}, 32'd1);
    end
    byte_ready_i = 1'b1;
    wait_done(cyc);
    check("bp_cksum", {24'b0, cksum_o}, {24'b0, CK_BASIC});
    tick();

    // Illegal DLC values
    start(3'd0, 4'd0, 8'h00);
    check("err_dlc0", {31'b0, err_o}, 32'd1);
    check("err0_busy", {31'b0, busy_o}, 32'd0);
    check("err0_valid", {31'b0, byte_valid_o}, 32'd0);
    tick();
    check("err0_pulse", {31'b0, err_o}, 32'd0);
    start(3'd0, 4'd9, 8'h00);
    check("err_dlc9", {31'b0, err_o}, 32'd1);
    check("err9_busy", {31'b0, busy_o}, 32'd0);
    tick();

    // Writes during LOAD and mid-frame are not seen; start while busy ignored
    exp_q.push_back(8'h55); exp_q.push_back(8'h93); exp_q.push_back(8'hE5); exp_q.push_back(8'h00);
    exp_q.push_back(CK_BASIC);
    start(3'd0, 4'd4, 8'h4A);
    wr(4'd0, 32'h11223344);
    wr(4'd1, 32'hAABBCCDD);
    start(3'd7, 4'd8, 8'h00);
    check("busy_start_err", {31'b0, err_o}, 32'd0);
    wait_done(cyc);
    check("busy_cksum", {24'b0, cksum_o}, {24'b0, CK_BASIC});
    tick(); tick();
    check("no_restart", {31'b0, busy_o}, 32'd0);
    check("cksum_hold", {24'b0, cksum_o}, {24'b0, CK_BASIC});

    // Reset abort after three bytes of slot 7
    for (int i = 0; i < 3; i++) exp_q.push_back(8'hFF);
    start(3'd7, 4'd8, 8'h00);
    tick(); tick(); tick(); tick();
    preset_i = 1'b0;
    #1;
    check("abort_valid", {31'b0, byte_valid_o}, 32'd0);
    check("abort_busy", {31'b0, busy_o}, 32'd0);
    check("abort_cksum", {24'b0, cksum_o}, 32'd0);
    tick();
    preset_i = 1'b1;
    tick(); tick();
    check("abort_no_done", {31'b0, done_o}, 32'd0);
    check("abort_idle", {31'b0, busy_o}, 32'd0);

    // Memory was cleared: slot 0 now reads as zeros
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    start(3'd0, 4'd8, 8'h00);
    wait_done(cyc);
    check("post_rst_cksum", {24'b0, cksum_o}, 32'hFF);
    tick();
    check("queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lin_tx_frame_feeder.md
Name: lin_tx_frame_feeder

Overview:
- Downstream consumer of the APB converter's TX-memory write port (tx_mem_we / tx_addr / tx_mem_data).
- Holds a 16x32 TX data memory organised as 8 frame slots of 2 words each.
- On a start command, streams a slot's 1..8 data bytes, then the LIN checksum byte, to the LIN transmit serializer over a valid/ready byte handshake.

Parameters:
- data_width, 32, write-data width (fixed at 32 for byte packing).
- mem_addr_width, 4, TX memory word address width (16 words).

Ports:
- pclk  input  1  system clock
- preset_i  input  1  reset, asynchronous, active-low
- tx_mem_we  input  1  memory write enable from converter
- tx_addr  input  mem_addr_width  memory word address
- tx_mem_data  input  data_width  memory write data
- start_i  input  1  start-frame pulse
- slot_i  input  3  frame slot; words {slot_i,0} and {slot_i,1}
- dlc_i  input  4  number of data bytes, legal 1..8
- byte_o  output  8  byte to serializer
- byte_valid_o  output  1  byte_o valid
- byte_ready_i  input  1  serializer accepts byte
- busy_o  output  1  frame in progress
- done_o  output  1  one-cycle pulse, frame complete
- err_o  output  1  one-cycle pulse, illegal dlc_i
- cksum_o  output  8  checksum of last frame

Behaviour:
- Reset (preset_i low, async):
  - All outputs 0, FSM IDLE.
  - All 16 memory words cleared to 0.
  - Shadow register, byte counter and sum cleared.
- Memory writes: on any cycle with tx_mem_we=1, mem[tx_addr] <= tx_mem_data. Writes are accepted in every FSM state. Reads are asynchronous from the flop array.
- Byte packing: little-endian.
  - Byte k is shadow[8k+7:8k] of the 64-bit value {mem[{slot,1}], mem[{slot,0}]}.
  - Byte 0 = word0[7:0].
- FSM states: IDLE, LOAD, SEND_DATA, SEND_CKSUM.
- IDLE:
  - start_i=1 with dlc_i in 1..8: latch slot_i and dlc_i, sum <= init, go to LOAD. Init is 0 for classic checksum; see Optional Feature.
  - start_i=1 with dlc_i=0 or dlc_i>8: err_o pulses next cycle, stay IDLE.
- LOAD (1 cycle):
  - Capture both slot words into the shadow register; counter <= 0; go to SEND_DATA.
  - Writes to the active slot after LOAD do not affect the frame in flight.
  - A write in the LOAD cycle itself is not captured; the pre-write value is used.
- SEND_DATA:
  - byte_valid_o=1, byte_o = shadow byte[counter].
  - Transfer occurs on valid && ready. On transfer: sum <= sum + byte with end-around carry (9-bit result; if bit 8 set, add 1 back into the 8-bit sum); counter++.
  - After byte dlc-1 transfers, go to SEND_CKSUM.
  - Holding rule: while ready=0, byte_o and valid are held stable.
- SEND_CKSUM:
  - byte_o = ~sum, byte_valid_o=1.
  - On transfer: cksum_o <= ~sum, go to IDLE; done_o pulses that next cycle.
- busy_o = 1 in LOAD, SEND_DATA and SEND_CKSUM; it is 0 in the done_o cycle.
- start_i while busy_o=1 is ignored (no err_o, no restart).
- Latency:
  - start_i sampled at cycle N: LOAD at N+1, first byte_valid_o at N+2.
  - Minimum frame length with ready tied high: dlc+3 cycles from start to done_o.
- byte_valid_o is never 1 in IDLE or LOAD.
- byte_valid_o stays 1 back-to-back across data→checksum when ready=1.
- cksum_o holds its value until the next completed frame.
- Reset mid-frame: immediate abort; valid, busy and done drop to 0; no done_o is generated after reset release.

Optional Feature:
- Macro: LIN_ENHANCED_CKSUM_EN.
- Defined: adds input pid_i [7:0], latched at start. Sum init = pid_i, giving the LIN 2.x enhanced checksum over PID plus data.
- Undefined: pid_i port absent; sum init = 0, giving the classic checksum over data only.

Test Plan:
- Classic checksum, basic frame:
  - Stimulus: write mem[0]=0x00E59355, then start slot 0, dlc=3, ready=1.
  - Response: bytes 0x55, 0x93, 0xE5, 0x31; done_o pulse; cksum_o=0x31; first valid 2 cycles after start.
- Enhanced checksum (LIN_ENHANCED_CKSUM_EN defined):
  - Stimulus: same data as above, pid_i=0x4A.
  - Response: checksum byte 0xE6.
- Full-length frame, carry wrap:
  - Stimulus: slot 7 (mem[14], mem[15]) = 0xFFFFFFFF, dlc=8.
  - Response: eight 0xFF bytes, checksum 0x00.
- Backpressure:
  - Stimulus: ready low for 5 cycles at byte 1.
  - Response: byte_o/byte_valid_o stable at 0x93/1; no byte skipped or duplicated.
- Illegal DLC:
  - Stimulus: start with dlc=0, then with dlc=9.
  - Response: err_o pulse each time; busy_o and byte_valid_o remain 0.
- Busy-time writes, restart and reset abort:
  - Writes to the active slot mid-frame: the old bytes are transmitted.
  - start_i while busy: ignored.
  - preset_i low after byte 2: all outputs 0, memory 0, and the next frame is valid.
